// File: rtl/stream_light_pkg.sv
// Shared types and helpers for the stream light pattern engine.
// Mode encoding and prescaler step-period calculation.
package stream_light_pkg;

    typedef enum logic [1:0] {
        ROTATE = 2'd0,
        BOUNCE = 2'd1,
        FILL   = 2'd2,
        BLINK  = 2'd3
    } mode_e;

    function automatic int unsigned step_limit(
        input int unsigned base,
        input logic [1:0]  speed
    );
        return base >> speed;
    endfunction

endpackage

// File: rtl/stream_light_multi_prescaler.sv
// Step-rate prescaler: emits a one-cycle tick every (DIV_BASE >> Speed) cycles.
// Clear restarts the count; Stop freezes it.
module tick_prescaler
    import stream_light_pkg::*;
#(
    parameter int unsigned DIV_BASE = 25_000_000,
    parameter int unsigned CNT_W    = $clog2(DIV_BASE)
) (
    input  logic       CLK,
    input  logic       Reset,
    input  logic       Stop,
    input  logic       Clear,
    input  logic [1:0] Speed,
    output logic       tick
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] last;

    // >= rather than == so a shortened period never has to wrap around
    assign last = CNT_W'(step_limit(DIV_BASE, Speed) - 1);
    assign tick = !Reset && !Stop && !Clear && (cnt >= last);

    // Count toward the period end, restarting on tick, clear or reset
    always_ff @(posedge CLK) begin
        if (Reset || Clear) begin
            cnt <= '0;
        end else if (!Stop) begin
            cnt <= tick ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/stream_light_multi.sv
// N-LED pattern engine: rotate, bounce, fill and blink with speed,
// stop and reverse control; registered LED bank and Step strobe.
module stream_light_multi
    import stream_light_pkg::*;
#(
    parameter int unsigned N_LED    = 16,
    parameter int unsigned DIV_BASE = 25_000_000,
    parameter int unsigned CNT_W    = $clog2(DIV_BASE)
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             Stop,
    input  logic             Reverse,
    input  logic [1:0]       Mode,
    input  logic [1:0]       Speed,
    output logic [N_LED-1:0] LED,
    output logic             Step
);

    localparam int unsigned PW = $clog2(N_LED);
    localparam int unsigned LW = $clog2(N_LED + 1);
    localparam logic [PW-1:0] POS_MAX = PW'(N_LED - 1);
    localparam logic [LW-1:0] LVL_MAX = LW'(N_LED);
    localparam logic [LW-1:0] LVL_MIN = LW'(1);

    mode_e         mode_q;
    logic [PW-1:0] pos;
    logic          dir;
    logic [LW-1:0] level;
    logic          tick;
    logic          mode_chg;

    logic [PW-1:0] rot_nx;
    logic [PW-1:0] bnc_nx;
    logic          bnc_dir;
    logic [LW-1:0] lvl_nx;
    logic          e_dn;

    function automatic logic [N_LED-1:0] onehot(input logic [PW-1:0] p);
        logic [N_LED-1:0] v;
        for (int i = 0; i < int'(N_LED); i++) v[i] = (p == PW'(i));
        return v;
    endfunction

    function automatic logic [N_LED-1:0] fill(input logic [LW-1:0] l);
        logic [N_LED-1:0] v;
        for (int i = 0; i < int'(N_LED); i++) v[i] = (LW'(i) < l);
        return v;
    endfunction

    assign mode_chg = (mode_e'(Mode) != mode_q);

    tick_prescaler #(
        .DIV_BASE(DIV_BASE),
        .CNT_W   (CNT_W)
    ) u_presc (
        .CLK  (CLK),
        .Reset(Reset),
        .Stop (Stop),
        .Clear(mode_chg),
        .Speed(Speed),
        .tick (tick)
    );

    // Next position/level for each pattern, with explicit end-point wraps
    always_comb begin
        rot_nx  = pos;
        bnc_nx  = pos;
        bnc_dir = dir;
        lvl_nx  = level;
        e_dn    = dir ^ Reverse;
        if (Reverse) rot_nx = (pos == '0) ? POS_MAX : pos - PW'(1);
        else         rot_nx = (pos == POS_MAX) ? '0 : pos + PW'(1);
        if (!e_dn && pos == POS_MAX) begin
            bnc_nx  = pos - PW'(1);
            bnc_dir = ~dir;
        end else if (e_dn && pos == '0) begin
            bnc_nx  = pos + PW'(1);
            bnc_dir = ~dir;
        end else begin
            bnc_nx = e_dn ? pos - PW'(1) : pos + PW'(1);
        end
        if (Reverse) lvl_nx = (level == LVL_MIN) ? LVL_MAX : level - LW'(1);
        else         lvl_nx = (level == LVL_MAX) ? LVL_MIN : level + LW'(1);
    end

    // Pattern state and LED register: reset, then mode restart, then tick
    always_ff @(posedge CLK) begin
        if (Reset) begin
            mode_q <= ROTATE;
            pos    <= '0;
            dir    <= 1'b0;
            level  <= LVL_MIN;
            LED    <= N_LED'(1);
            Step   <= 1'b0;
        end else if (mode_chg) begin
            mode_q <= mode_e'(Mode);
            pos    <= '0;
            dir    <= 1'b0;
            level  <= LVL_MIN;
            LED    <= (mode_e'(Mode) == BLINK) ? '1 : N_LED'(1);
            Step   <= 1'b0;
        end else if (tick) begin
            Step <= 1'b1;
            unique case (mode_q)
                ROTATE: begin
                    pos <= rot_nx;
                    LED <= onehot(rot_nx);
                end
                BOUNCE: begin
                    pos <= bnc_nx;
                    dir <= bnc_dir;
                    LED <= onehot(bnc_nx);
                end
                FILL: begin
                    level <= lvl_nx;
                    LED   <= fill(lvl_nx);
                end
                BLINK: begin
                    LED <= ~LED;
                end
            endcase
        end else begin
            Step <= 1'b0;
        end
    end

endmodule

// File: doc/stream_light_multi.md
Name: stream_light_multi

Overview:
- Parametrised successor to the 16-LED stream light: N-LED pattern engine with four display modes, four speeds, stop and reverse.
- Sits under the board top; drives the LED bank directly from switch/button inputs.
- Registered LED outputs plus a one-cycle Step strobe for debug and downstream sync.

Parameters:
- N_LED, 16, number of LEDs driven; must be >= 2.
- DIV_BASE, 25_000_000, CLK cycles per step at Speed=0; must be >= 8.
- CNT_W, $clog2(DIV_BASE), prescaler counter width (derived).

Ports:
- CLK  input  1  system clock.
- Reset  input  1  synchronous, active-high reset.
- Stop  input  1  level; 1 freezes pattern and prescaler.
- Reverse  input  1  level; 1 inverts the direction of travel.
- Mode  input  2  0 ROTATE, 1 BOUNCE, 2 FILL, 3 BLINK.
- Speed  input  2  step period = DIV_BASE >> Speed cycles.
- LED  output  N_LED  registered pattern.
- Step  output  1  registered one-cycle pulse, high in the cycle LED takes a new step value.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset (wins over everything): cnt=0, pos=0, dir=up, level=1, mode_q=ROTATE, LED=1 (bit 0), Step=0.
- Prescaler: limit = DIV_BASE >> Speed.
  - Each cycle with !Stop: if cnt >= limit-1, then cnt<=0 and tick; else cnt++.
  - The >= compare makes a Speed decrease take effect without an overflow wrap.
  - Stop=1: cnt, LED and all state hold; Step=0.
- Mode change: if Mode != mode_q (and not Reset), restart and do not tick that cycle.
  - Restart sets mode_q<=Mode, cnt<=0, pos<=0, dir<=up, level<=1, Step<=0, and LED to the restart pattern.
  - Restart pattern: ROTATE/BOUNCE/FILL = 1; BLINK = all ones.
  - After Reset with Mode!=0, the restart occurs one cycle after reset deasserts.
  - Mode change has priority over tick and over Stop.
- On tick, the LED update and Step=1 land on the same edge. Otherwise Step=0.
- ROTATE:
  - Reverse=0: pos<=pos+1, wrapping N_LED-1 -> 0.
  - Reverse=1: pos<=pos-1, wrapping 0 -> N_LED-1.
  - LED = one-hot(pos).
- BOUNCE:
  - Effective direction e = dir XOR Reverse.
  - Moving up at pos=N_LED-1, or down at pos=0: toggle dir and step one place the other way in the same tick.
  - Otherwise step in direction e. No tick ever holds an end position.
  - LED = one-hot(pos).
- FILL:
  - level ranges 1..N_LED; LED = (1<<level)-1, i.e. the low `level` bits are set.
  - Reverse=0: level++, wrapping N_LED -> 1.
  - Reverse=1: level--, wrapping 1 -> N_LED.
- BLINK: LED <= ~LED on each tick.
- Reverse changes only affect the next tick and never restart the pattern.
- Width rules: pos uses $clog2(N_LED) bits and level uses $clog2(N_LED+1) bits. Wrap is explicit compare, not power-of-two modulo, so non-power-of-two N_LED is valid.

Decomposition:
- Package stream_light_pkg holds:
  - enum mode_e {ROTATE, BOUNCE, FILL, BLINK} (2 bits);
  - function step_limit(base, speed).
- Sub-module tick_prescaler (params DIV_BASE, CNT_W):
  - inputs CLK, Reset, Stop, Clear, Speed; output tick.
  - Clear is driven by mode restart.
- The pattern FSM and LED register stay in stream_light_multi.

Test Plan:
- Bench config N_LED=4, DIV_BASE=8.
- 1. Reset, Mode=0, Speed=0 -> LED=0001. Then Step every 8 cycles with LED 0010, 0100, 1000, 0001 (wrap). Reverse=1 from 0001 -> 1000.
- 2. Mode=1, Speed=3 (step every cycle) -> LED 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010. Toggle Reverse at LED=0100 while moving up -> next LED 0010.
- 3. Mode=2, Speed=2 (every 2 cycles) -> 0001, 0011, 0111, 1111, 0001. With Reverse=1 from 0001 -> 1111, 0111.
- 4. Stop=1 for 20 cycles mid-pattern -> LED constant, Step never high. On release, the next Step arrives after the remaining prescaler count (e.g. cnt=5 at Speed=0 gives Step 3 cycles later).
- 5. Mode 0->3 switched in the same cycle a tick is due -> no Step that cycle; LED=1111 next edge; then Step every 8 cycles with LED 0000, 1111.
- 6. Reset asserted mid-BOUNCE with Mode held at 1 -> LED=0001 and Step=0 at the reset edge. One cycle later the restart fires (LED stays 0001, cnt=0), and the first Step comes 8 cycles after that with LED=0010.
